// File: rtl/rx_pcs_pkg.sv
// Shared constants for the rx PCS lane logic: deskew state encoding and default sizing.
package rx_pcs_pkg;

    localparam int unsigned LANES_DEF     = 4;
    localparam int unsigned MAX_SKEW_DEF  = 16;
    localparam int unsigned ERR_LIMIT_DEF = 3;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned SKEW_W  = 8;
    localparam int unsigned MISM_W  = 4;
    localparam int unsigned MISM_EW = MISM_W + 1;

    localparam logic [STATE_W-1:0] ST_HUNT   = 2'd0;
    localparam logic [STATE_W-1:0] ST_DESKEW = 2'd1;
    localparam logic [STATE_W-1:0] ST_LOCKED = 2'd2;

endpackage

// File: rtl/rx_lane_deskew_ctrl.sv
// Pop sequencer for LANES rx FIFO output stages: hunts for sync on every lane,
// discards leading data on early lanes, then pops all lanes in lock-step.
module rx_lane_deskew_ctrl
    import rx_pcs_pkg::*;
#(
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned MAX_SKEW  = MAX_SKEW_DEF,
    parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_enable,
    input  logic              force_hunt,
    input  logic [LANES-1:0]  canpop_collector,
    input  logic [LANES-1:0]  issync_collector,
    output logic [LANES-1:0]  pop_collector,
    output logic              aligned_word,
    output logic              aligned,
    output logic              skew_err,
    output logic              lock_lost,
    output logic [MISM_W-1:0] mism_cnt
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [SKEW_W-1:0]  skew_cnt_q, skew_cnt_d;
    logic [MISM_W-1:0]  mism_q, mism_d;
    logic               skip_q, skip_d;
    logic               aligned_q, aligned_d;
    logic               skew_err_q, skew_err_d;
    logic               lock_lost_q, lock_lost_d;

    logic [LANES-1:0]   pop_c;
    logic               aligned_word_c;
    logic [LANES-1:0]   syn;
    logic [LANES-1:0]   discard;
    logic               all_can, all_syn, any_syn;
    logic [MISM_EW-1:0] mism_inc;

    assign syn      = issync_collector & canpop_collector;
    assign discard  = canpop_collector & ~issync_collector;
    assign all_can  = &canpop_collector;
    assign all_syn  = &syn;
    assign any_syn  = |syn;
    assign mism_inc = {1'b0, mism_q} + MISM_EW'(1);

    // Next-state, counters and pop decode
    always_comb begin
        state_d        = state_q;
        skew_cnt_d     = skew_cnt_q;
        mism_d         = mism_q;
        skip_d         = skip_q;
        skew_err_d     = 1'b0;
        lock_lost_d    = 1'b0;
        pop_c          = '0;
        aligned_word_c = 1'b0;

        case (state_q)
            ST_HUNT: begin
                pop_c = discard;
                if (all_syn) begin
                    pop_c   = canpop_collector;
                    state_d = ST_LOCKED;
                    mism_d  = '0;
                    skip_d  = 1'b0;
                end else if (any_syn) begin
                    state_d    = ST_DESKEW;
                    skew_cnt_d = '0;
                end
            end
            ST_DESKEW: begin
                pop_c      = discard;
                skew_cnt_d = skew_cnt_q + SKEW_W'(1);
                if (all_syn) begin
                    pop_c      = canpop_collector;
                    state_d    = ST_LOCKED;
                    mism_d     = '0;
                    skip_d     = 1'b0;
                    skew_cnt_d = '0;
                end else if (skew_cnt_q == SKEW_W'(MAX_SKEW - 1)) begin
                    // Give up: flush the sync heads we were holding back.
                    pop_c      = canpop_collector;
                    skew_err_d = 1'b1;
                    state_d    = ST_HUNT;
                    skew_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                if (all_can) begin
                    if (skip_q) begin
                        pop_c          = canpop_collector;
                        aligned_word_c = 1'b1;
                        skip_d         = 1'b0;
                    end else if (all_syn || !any_syn) begin
                        pop_c          = canpop_collector;
                        aligned_word_c = 1'b1;
                        if (all_syn) begin
                            mism_d = '0;
                        end
                    end else if (mism_inc < MISM_EW'(ERR_LIMIT)) begin
                        mism_d = mism_inc[MISM_W-1:0];
                        skip_d = 1'b1;
                    end else begin
                        lock_lost_d = 1'b1;
                        state_d     = ST_HUNT;
                        mism_d      = '0;
                        skip_d      = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = ST_HUNT;
                skew_cnt_d = '0;
                mism_d     = '0;
                skip_d     = 1'b0;
            end
        endcase

        if (force_hunt) begin
            pop_c          = '0;
            aligned_word_c = 1'b0;
            state_d        = ST_HUNT;
            skew_cnt_d     = '0;
            mism_d         = '0;
            skip_d         = 1'b0;
            skew_err_d     = 1'b0;
            lock_lost_d    = (state_q == ST_LOCKED);
        end

        if (!in_enable) begin
            pop_c          = '0;
            aligned_word_c = 1'b0;
        end

        aligned_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_HUNT;
            skew_cnt_q  <= '0;
            mism_q      <= '0;
            skip_q      <= 1'b0;
            aligned_q   <= 1'b0;
            skew_err_q  <= 1'b0;
            lock_lost_q <= 1'b0;
        end else if (in_enable) begin
            state_q     <= state_d;
            skew_cnt_q  <= skew_cnt_d;
            mism_q      <= mism_d;
            skip_q      <= skip_d;
            aligned_q   <= aligned_d;
            skew_err_q  <= skew_err_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign pop_collector = pop_c;
    assign aligned_word  = aligned_word_c;
    assign aligned       = aligned_q;
    assign skew_err      = skew_err_q;
    assign lock_lost     = lock_lost_q;
    assign mism_cnt      = mism_q;

endmodule

// File: tb/tb_rx_lane_deskew_ctrl.sv
// Bench for rx_lane_deskew_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a rule-level reference model.
module tb_rx_lane_deskew_ctrl;

    localparam int unsigned MAX_SKEW  = 16;
    localparam int unsigned ERR_LIMIT = 3;

    logic       clock;
    logic       reset_n;
    logic       in_enable;
    logic       force_hunt;
    logic [3:0] canpop_collector;
    logic [3:0] issync_collector;
    logic [3:0] pop_collector;
    logic       aligned_word;
    logic       aligned;
    logic       skew_err;
    logic       lock_lost;
    logic [3:0] mism_cnt;

    rx_lane_deskew_ctrl #(
        .LANES     (4),
        .MAX_SKEW  (MAX_SKEW),
        .ERR_LIMIT (ERR_LIMIT)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_enable        (in_enable),
        .force_hunt       (force_hunt),
        .canpop_collector (canpop_collector),
        .issync_collector (issync_collector),
        .pop_collector    (pop_collector),
        .aligned_word     (aligned_word),
        .aligned          (aligned),
        .skew_err         (skew_err),
        .lock_lost        (lock_lost),
        .mism_cnt         (mism_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Sampled DUT values from the last tick
    logic [3:0] s_pop;
    logic       s_aw, s_aligned, s_serr, s_ll, s_rst;
    logic [3:0] s_mism;

    // Reference model: tracks what the lanes should see, in terms of modes and event counts
    typedef enum int {M_SEARCH, M_ALIGN, M_LOCK} mode_t;
    mode_t      m_mode;
    int         m_spent;
    int         m_errs;
    bit         m_skip_next;
    bit         m_aligned, m_serr, m_ll;
    logic [3:0] e_pop;
    bit         e_aw;

    task automatic model_step(input bit rst, input bit en, input bit fh,
                              input logic [3:0] cp, input logic [3:0] sy);
        logic [3:0] s;
        bit full, none, everyone;
        mode_t was;
        s        = sy & cp;
        full     = (s == 4'hF);
        none     = (s == 4'h0);
        everyone = (cp == 4'hF);
        e_pop    = 4'h0;
        e_aw     = 1'b0;
        if (!rst) begin
            m_mode = M_SEARCH; m_spent = 0; m_errs = 0; m_skip_next = 0;
            m_aligned = 0; m_serr = 0; m_ll = 0;
            return;
        end
        if (!en) return;
        was    = m_mode;
        m_serr = 0;
        m_ll   = 0;
        if (fh) begin
            m_mode = M_SEARCH; m_spent = 0; m_errs = 0; m_skip_next = 0;
            m_ll = (was == M_LOCK);
            m_aligned = 0;
            return;
        end
        case (was)
            M_SEARCH, M_ALIGN: begin
                e_pop = cp & ~sy;
                if (full) begin
                    e_pop = cp; m_mode = M_LOCK; m_errs = 0; m_skip_next = 0;
                end else if (was == M_SEARCH) begin
                    if (!none) begin m_mode = M_ALIGN; m_spent = 0; end
                end else begin
                    m_spent++;
                    if (m_spent == int'(MAX_SKEW)) begin
                        m_serr = 1; e_pop = cp; m_mode = M_SEARCH;
                    end
                end
            end
            M_LOCK: begin
                if (everyone) begin
                    if (m_skip_next || full || none) begin
                        e_pop = 4'hF; e_aw = 1;
                        if (!m_skip_next && full) m_errs = 0;
                        m_skip_next = 0;
                    end else begin
                        m_errs++;
                        if (m_errs >= int'(ERR_LIMIT)) begin
                            m_ll = 1; m_mode = M_SEARCH; m_errs = 0;
                        end else begin
                            m_skip_next = 1;
                        end
                    end
                end
            end
            default: m_mode = M_SEARCH;
        endcase
        m_aligned = (m_mode == M_LOCK);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, sample combinational outputs mid-cycle, registered outputs after the edge
    task automatic tick(input bit rst, input bit en, input bit fh,
                        input logic [3:0] cp, input logic [3:0] sy);
        reset_n          = rst;
        in_enable        = en;
        force_hunt       = fh;
        canpop_collector = cp;
        issync_collector = sy;
        model_step(rst, en, fh, cp, sy);
        @(negedge clock);
        s_pop = pop_collector;
        s_aw  = aligned_word;
        s_rst = rst;
        @(posedge clock);
        #1;
        s_aligned = aligned;
        s_serr    = skew_err;
        s_ll      = lock_lost;
        s_mism    = mism_cnt;
    endtask

    task automatic cmp_model(input string tag);
        if (s_rst) begin
            chk({tag, ".pop"}, 32'(s_pop), 32'(e_pop));
            chk({tag, ".aligned_word"}, 32'(s_aw), 32'(e_aw));
        end
        chk({tag, ".aligned"}, 32'(s_aligned), 32'(m_aligned));
        chk({tag, ".mism_cnt"}, 32'(s_mism), 32'(m_errs));
        chk({tag, ".skew_err"}, 32'(s_serr), 32'(m_serr));
        chk({tag, ".lock_lost"}, 32'(s_ll), 32'(m_ll));
    endtask

    typedef struct {
        bit         en;
        bit         fh;
        logic [3:0] cp;
        logic [3:0] sy;
        logic [3:0] pop;
        bit         aw;
        bit         al;
        logic [3:0] mism;
        bit         serr;
        bit         ll;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int found;
        logic [3:0] flush_pop;
        logic [3:0] sy_r, cp_r;

        // Skewed lock (lanes reach sync after 0,2,3,5 discards), then mixed-sync lock loss with a recovery
        tbl[0]  = '{1'b1, 1'b0, 4'hF, 4'h1, 4'hE, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 4'hF, 4'h1, 4'hE, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'hF, 4'h3, 4'hC, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'hF, 4'h7, 4'h8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4'hF, 4'h7, 4'h8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'hF, 4'h5, 4'h0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'hF, 4'h5, 4'hF, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 4'hF, 4'h5, 4'h0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 4'hF, 4'h5, 4'h0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 4'd1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 4'hF, 4'h5, 4'h0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 4'd2, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 4'hF, 4'h5, 4'h0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0};

        // Reset state
        tick(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'hF);
        chk("reset.aligned", 32'(s_aligned), 32'd0);
        chk("reset.mism_cnt", 32'(s_mism), 32'd0);
        chk("reset.skew_err", 32'(s_serr), 32'd0);
        chk("reset.lock_lost", 32'(s_ll), 32'd0);

        for (int i = 0; i < 20; i++) begin
            tick(1'b1, tbl[i].en, tbl[i].fh, tbl[i].cp, tbl[i].sy);
            chk($sformatf("tbl[%0d].pop", i), 32'(s_pop), 32'(tbl[i].pop));
            chk($sformatf("tbl[%0d].aligned_word", i), 32'(s_aw), 32'(tbl[i].aw));
            chk($sformatf("tbl[%0d].aligned", i), 32'(s_aligned), 32'(tbl[i].al));
            chk($sformatf("tbl[%0d].mism_cnt", i), 32'(s_mism), 32'(tbl[i].mism));
            chk($sformatf("tbl[%0d].skew_err", i), 32'(s_serr), 32'(tbl[i].serr));
            chk($sformatf("tbl[%0d].lock_lost", i), 32'(s_ll), 32'(tbl[i].ll));
        end

        // Timeout: lane2 never shows sync
        tick(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'hB);
        cmp_model("to_entry");
        found     = -1;
        flush_pop = 4'h0;
        for (int n = 1; n <= 40; n++) begin
            tick(1'b1, 1'b1, 1'b0, 4'hF, 4'hB);
            cmp_model($sformatf("to_c%0d", n));
            if (s_serr) begin
                found     = n;
                flush_pop = s_pop;
                break;
            end
        end
        chk("timeout.cycles", 32'(found), 32'd16);
        chk("timeout.flush_pop", 32'(flush_pop), 32'hF);
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'hB);
        chk("timeout.pulse_width", 32'(s_serr), 32'd0);
        chk("timeout.rehunt_pop", 32'(s_pop), 32'h4);
        cmp_model("to_after");

        // Enable gating while locked
        tick(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, (k % 2) == 0, 1'b0, 4'hF, (k == 1) ? 4'h5 : 4'h0);
            chk($sformatf("gate%0d.pop", k), 32'(s_pop), (k % 2) == 0 ? 32'hF : 32'h0);
            chk($sformatf("gate%0d.aligned", k), 32'(s_aligned), 32'd1);
            chk($sformatf("gate%0d.mism_cnt", k), 32'(s_mism), 32'd0);
            cmp_model($sformatf("gate%0d", k));
        end

        // force_hunt mid-LOCKED with a pending skip
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'h5);
        chk("fh.pre_mism", 32'(s_mism), 32'd1);
        tick(1'b1, 1'b1, 1'b1, 4'hF, 4'hF);
        chk("fh.pop", 32'(s_pop), 32'h0);
        chk("fh.aligned", 32'(s_aligned), 32'd0);
        chk("fh.lock_lost", 32'(s_ll), 32'd1);
        chk("fh.mism_cnt", 32'(s_mism), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
        chk("fh.lock_lost_once", 32'(s_ll), 32'd0);
        cmp_model("fh_after");

        // Reset mid-DESKEW and mid-LOCKED, with enable low
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'h1);
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'h1);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h1);
        cmp_model("rst_deskew");
        tick(1'b1, 1'b1, 1'b0, 4'hF, 4'hF);
        chk("rst.relock_aligned", 32'(s_aligned), 32'd1);
        tick(1'b0, 1'b0, 1'b0, 4'hF, 4'h0);
        chk("rst.locked_aligned", 32'(s_aligned), 32'd0);
        cmp_model("rst_locked");

        // Randomized traffic against the model
        for (int r = 0; r < 3000; r++) begin
            int pick;
            for (int b = 0; b < 4; b++) cp_r[b] = ($urandom_range(0, 7) != 0);
            pick = int'($urandom_range(0, 9));
            if (pick < 4)      sy_r = 4'hF;
            else if (pick < 7) sy_r = 4'h0;
            else               sy_r = 4'($urandom_range(0, 15));
            tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 39) == 0), cp_r, sy_r);
            cmp_model($sformatf("rnd%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
